// File: rtl/ofdm_frame_extractor.sv
// ofdm_frame_extractor
// Strips the cyclic prefix from each OFDM symbol of a detected frame and
// forwards cfg_num_symbols FFT-length symbols to the FFT stage. Samples
// outside a frame are discarded.
//
// Ports:
//   ce_clk, ce_rst_n            block clock, asynchronous active-low reset
//   clear                       synchronous abort to IDLE, drops held beat
//   cfg_fft_len/cp_len/num_sym  frame geometry, sampled on the frame strobe
//   s_axis_*                    IQ stream from the detector (tuser = strobe)
//   m_axis_*                    extracted samples (tuser = frame start,
//                               tlast = last sample of each symbol)
//   sts_frames                  completed frames (wraps)
//   sts_ignored_triggers        strobes seen outside IDLE (wraps)
//   busy                        state is not IDLE
//
// Handshake: a beat transfers on a cycle where valid && ready. Once valid is
// raised, data/user/last hold until the transfer. The output register is
// "free" when it is empty or is being drained this cycle.
module ofdm_frame_extractor #(
  parameter int ITEM_W    = 32,
  parameter int MAX_LEN_W = 12,
  parameter int SYM_CNT_W = 8,
  parameter int STS_W     = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst_n,
  input  logic                 clear,
  input  logic [MAX_LEN_W-1:0] cfg_fft_len,
  input  logic [MAX_LEN_W-1:0] cfg_cp_len,
  input  logic [SYM_CNT_W-1:0] cfg_num_symbols,
  input  logic [ITEM_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tuser,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [ITEM_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [STS_W-1:0]     sts_frames,
  output logic [STS_W-1:0]     sts_ignored_triggers,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CP, ST_DATA} state_t;

  localparam logic [MAX_LEN_W-1:0] LEN_ONE = MAX_LEN_W'(1);
  localparam logic [SYM_CNT_W-1:0] SYM_ONE = SYM_CNT_W'(1);
  localparam logic [STS_W-1:0]     STS_ONE = STS_W'(1);

  state_t               state_q, state_d;
  logic [MAX_LEN_W-1:0] cp_cnt_q, cp_cnt_d;
  logic [MAX_LEN_W-1:0] dat_cnt_q, dat_cnt_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [MAX_LEN_W-1:0] fft_len_q, fft_len_d;
  logic [MAX_LEN_W-1:0] cp_len_q, cp_len_d;
  logic [SYM_CNT_W-1:0] num_sym_q, num_sym_d;
  logic [ITEM_W-1:0]    tdata_q, tdata_d;
  logic                 tuser_q, tuser_d;
  logic                 tlast_q, tlast_d;
  logic                 tvalid_q, tvalid_d;
  logic [STS_W-1:0]     frames_q, frames_d;
  logic [STS_W-1:0]     ignored_q, ignored_d;

  logic out_free;
  logic fire;
  logic do_data;

  assign out_free = !tvalid_q || m_axis_tready;

  // In IDLE a strobe with cp_len=0 writes the output register directly, so
  // that one case must wait for a free stage; every other IDLE/CP beat is
  // discarded and always accepted.
  always_comb begin
    s_axis_tready = 1'b1;
    case (state_q)
      ST_DATA: s_axis_tready = out_free;
      ST_IDLE: s_axis_tready = out_free || !(s_axis_tuser && (cfg_cp_len == '0));
      default: s_axis_tready = 1'b1;
    endcase
  end

  assign fire = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    cp_cnt_d  = cp_cnt_q;
    dat_cnt_d = dat_cnt_q;
    sym_cnt_d = sym_cnt_q;
    fft_len_d = fft_len_q;
    cp_len_d  = cp_len_q;
    num_sym_d = num_sym_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    frames_d  = frames_q;
    ignored_d = ignored_q;
    do_data   = 1'b0;

    if (out_free) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fire && s_axis_tuser) begin
          fft_len_d = (cfg_fft_len == '0) ? LEN_ONE : cfg_fft_len;
          cp_len_d  = cfg_cp_len;
          num_sym_d = (cfg_num_symbols == '0) ? SYM_ONE : cfg_num_symbols;
          sym_cnt_d = '0;
          dat_cnt_d = '0;
          cp_cnt_d  = '0;
          // The strobe beat is CP sample 0, or data sample 0 without a CP.
          if (cfg_cp_len > LEN_ONE) begin
            state_d  = ST_CP;
            cp_cnt_d = LEN_ONE;
          end else if (cfg_cp_len == LEN_ONE) begin
            state_d = ST_DATA;
          end else begin
            do_data = 1'b1;
          end
        end
      end
      ST_CP: begin
        if (fire) begin
          if (cp_cnt_q == cp_len_q - LEN_ONE) begin
            state_d   = ST_DATA;
            dat_cnt_d = '0;
          end else begin
            cp_cnt_d = cp_cnt_q + LEN_ONE;
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          do_data = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The *_d config values equal the latched ones in DATA and the freshly
    // latched ones for the cp_len=0 strobe beat, so one path serves both.
    if (do_data) begin
      tdata_d  = s_axis_tdata;
      tvalid_d = 1'b1;
      tuser_d  = (sym_cnt_q == '0) && (dat_cnt_q == '0);
      tlast_d  = (dat_cnt_q == fft_len_d - LEN_ONE);
      if (tlast_d) begin
        if (sym_cnt_q + SYM_ONE == num_sym_d) begin
          state_d   = ST_IDLE;
          sym_cnt_d = '0;
          dat_cnt_d = '0;
          frames_d  = frames_q + STS_ONE;
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_ONE;
          dat_cnt_d = '0;
          if (cp_len_d == '0) begin
            state_d = ST_DATA;
          end else begin
            state_d  = ST_CP;
            cp_cnt_d = '0;
          end
        end
      end else begin
        dat_cnt_d = dat_cnt_q + LEN_ONE;
        state_d   = ST_DATA;
      end
    end

    if (fire && s_axis_tuser && (state_q != ST_IDLE)) begin
      ignored_d = ignored_q + STS_ONE;
    end

    // Abort wins over everything above, but status counters survive it.
    if (clear) begin
      state_d   = ST_IDLE;
      cp_cnt_d  = '0;
      dat_cnt_d = '0;
      sym_cnt_d = '0;
      tvalid_d  = 1'b0;
      tuser_d   = 1'b0;
      tlast_d   = 1'b0;
      frames_d  = frames_q;
      ignored_d = ignored_q;
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q   <= ST_IDLE;
      cp_cnt_q  <= '0;
      dat_cnt_q <= '0;
      sym_cnt_q <= '0;
      fft_len_q <= LEN_ONE;
      cp_len_q  <= '0;
      num_sym_q <= SYM_ONE;
      tdata_q   <= '0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      frames_q  <= '0;
      ignored_q <= '0;
    end else begin
      state_q   <= state_d;
      cp_cnt_q  <= cp_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      fft_len_q <= fft_len_d;
      cp_len_q  <= cp_len_d;
      num_sym_q <= num_sym_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      frames_q  <= frames_d;
      ignored_q <= ignored_d;
    end
  end

  assign m_axis_tdata         = tdata_q;
  assign m_axis_tuser         = tuser_q;
  assign m_axis_tlast         = tlast_q;
  assign m_axis_tvalid        = tvalid_q;
  assign sts_frames           = frames_q;
  assign sts_ignored_triggers = ignored_q;
  assign busy                 = (state_q != ST_IDLE);

endmodule
